// File: rtl/pipe_gap_gen_pkg.sv
// pipe_pkg: shared types and constants for the pipe-gap generator and the
// scroller that consumes its output.
//   gap_state_t    : reducer FSM encoding (IDLE, REDUCE)
//   GAP_RESET_ROW  : gap-top row used after reset (middle of the legal band)
package pipe_pkg;

  localparam int PIPE_RAND_W   = 10;
  localparam int PIPE_OUT_W    = 4;
  localparam int PIPE_RANGE    = 10;
  localparam int PIPE_MIN_TOP  = 1;
  localparam int PIPE_MAX_STEP = 4;

  localparam int GAP_RESET_ROW = PIPE_MIN_TOP + PIPE_RANGE / 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } gap_state_t;

endpackage

// File: rtl/pipe_gap_gen_if.sv
// pipe_gap_gen_if: request/result bundle between the pipe scroller and the
// gap generator.
//   req      : scroller -> generator, request a new gap row
//   rand_in  : scroller -> generator, LFSR value sampled on an accepted req
//   gap_top  : generator -> scroller, current gap-top row (held)
//   valid    : generator -> scroller, one-cycle pulse on a new gap_top
//   busy     : generator -> scroller, a request is being reduced
// Modports: master = requester side, slave = generator side.
interface pipe_gap_gen_if #(
  parameter int RAND_W = 10,
  parameter int OUT_W  = 4
);
  logic              req;
  logic [RAND_W-1:0] rand_in;
  logic [OUT_W-1:0]  gap_top;
  logic              valid;
  logic              busy;

  modport master (output req, output rand_in,
                  input  gap_top, input valid, input busy);
  modport slave  (input  req, input rand_in,
                  output gap_top, output valid, output busy);
endinterface

// File: rtl/pipe_gap_gen.sv
// pipe_gap_gen: turns a free-running LFSR value into a legal pipe-gap row.
// On an accepted req the random value is latched and reduced modulo RANGE by
// repeated subtraction (one subtraction per clock), then offset by MIN_TOP and
// presented on gap_top with a one-cycle valid pulse.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   gif    : pipe_gap_gen_if.slave (req, rand_in in; gap_top, valid, busy out)
// Optional feature: define PIPE_GAP_CLAMP_EN to limit each gap change to
// +/-MAX_STEP rows relative to the previous gap_top.
module pipe_gap_gen
  import pipe_pkg::*;
#(
  parameter int RAND_W   = PIPE_RAND_W,
  parameter int OUT_W    = PIPE_OUT_W,
  parameter int RANGE    = PIPE_RANGE,
  parameter int MIN_TOP  = PIPE_MIN_TOP,
  parameter int MAX_STEP = PIPE_MAX_STEP
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_gap_gen_if.slave        gif
);

  gap_state_t        state_q, state_d;
  logic [RAND_W-1:0] r_q, r_d;
  logic [OUT_W-1:0]  gap_top_q, gap_top_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [OUT_W-1:0]  cand;

  // Limit the step from prev to cand. Done one bit wider so prev+MAX_STEP
  // cannot wrap; the low side compares cand+MAX_STEP < prev to avoid the
  // underflow of prev-MAX_STEP.
  function automatic logic [OUT_W-1:0] clamp_gap(input logic [OUT_W-1:0] c,
                                                 input logic [OUT_W-1:0] prev);
    logic [OUT_W:0] cw, pw, step;
    cw   = {1'b0, c};
    pw   = {1'b0, prev};
    step = (OUT_W+1)'(MAX_STEP);
    if (cw > pw + step)
      clamp_gap = prev + step[OUT_W-1:0];
    else if (cw + step < pw)
      clamp_gap = prev - step[OUT_W-1:0];
    else
      clamp_gap = c;
  endfunction

  // r is below RANGE here, so its low OUT_W bits hold the whole value.
  assign cand = r_q[OUT_W-1:0] + OUT_W'(MIN_TOP);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    gap_top_d = gap_top_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gif.req) begin
          r_d     = gif.rand_in;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (r_q >= RAND_W'(RANGE)) begin
          r_d = r_q - RAND_W'(RANGE);
        end else begin
`ifdef PIPE_GAP_CLAMP_EN
          gap_top_d = clamp_gap(cand, gap_top_q);
`else
          gap_top_d = cand;
`endif
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REDUCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      gap_top_q <= OUT_W'(GAP_RESET_ROW);
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      gap_top_q <= gap_top_d;
    end
  end

  // Working remainder needs no reset: it is reloaded on every accepted req.
  always_ff @(posedge clk) begin
    r_q <= r_d;
  end

  assign gif.gap_top = gap_top_q;
  assign gif.valid   = valid_q;
  assign gif.busy    = busy_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
module tb_pipe_gap_gen;
  import pipe_pkg::*;

  localparam int RNG  = 10;
  localparam int MINT = 1;
  localparam int MSTP = 4;
  localparam int RST_ROW = 6;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  pipe_gap_gen_if #(.RAND_W(10), .OUT_W(4)) gif ();

  pipe_gap_gen dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues, filled by the driver, drained by the monitor.
  int q_gap[$];
  int q_lat[$];
  int q_edge[$];

  int prev_m;    // model's current gap_top
  int ready_at;  // edge count after which the model says the DUT is idle
  int last_gap;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: modulo reduction then optional step limit.
  function automatic int model_gap(input int r, input int prev);
    int c;
    c = (r % RNG) + MINT;
`ifdef PIPE_GAP_CLAMP_EN
    if (c > prev + MSTP) c = prev + MSTP;
    else if (c < prev - MSTP) c = prev - MSTP;
`endif
    return c;
  endfunction

  // Monitor: compare each valid pulse against the scoreboard; between
  // pulses gap_top must hold.
  always @(negedge clk) begin
    if (reset) begin
      last_gap = RST_ROW;
    end else if (gif.valid) begin
      if (q_gap.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=%0d required=none (cycle %0d)", gif.gap_top, cyc);
      end else begin
        int eg, el, ee;
        eg = q_gap.pop_front();
        el = q_lat.pop_front();
        ee = q_edge.pop_front();
        chk("gap_top", int'(gif.gap_top), eg);
        chk("latency", cyc - ee, el);
        chk("in_range", int'(gif.gap_top >= 4'(MINT) && gif.gap_top <= 4'(MINT+RNG-1)), 1);
`ifdef PIPE_GAP_CLAMP_EN
        chk("step_le_max", int'((int'(gif.gap_top) - last_gap <= MSTP) &&
                                (last_gap - int'(gif.gap_top) <= MSTP)), 1);
`endif
      end
      last_gap = int'(gif.gap_top);
    end else begin
      chk("gap_hold", int'(gif.gap_top), last_gap);
    end
  end

  // Drive one req once the model says the DUT is idle. track=1 pushes the
  // expected result; track=0 is used for a request that will be aborted.
  task automatic issue(input int r, input bit track);
    int e;
    @(posedge clk); #1;
    while (cyc < ready_at) begin
      @(posedge clk); #1;
    end
    gif.req     = 1'b1;
    gif.rand_in = 10'(r);
    e = cyc;
    if (track) begin
      prev_m = model_gap(r, prev_m);
      q_gap.push_back(prev_m);
      q_lat.push_back(r / RNG + 2);
      q_edge.push_back(e);
      ready_at = e + r / RNG + 2;
    end
    @(posedge clk); #1;
    gif.req     = 1'b0;
    gif.rand_in = 10'($urandom_range(0, 1023));
    if (track) chk("busy_after_req", int'(gif.busy), 1);
  endtask

  // Extra reqs while busy, including the one landing on the completion edge.
  task automatic spam(input int n);
    int k;
    k = n;
    while (cyc + 1 <= ready_at && k > 0) begin
      gif.req     = 1'b1;
      gif.rand_in = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
      gif.req = 1'b0;
      k--;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_gap.size() != 0 || cyc < ready_at + 1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n >= 300), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    prev_m   = RST_ROW;
    last_gap = RST_ROW;
    ready_at = 0;
    gif.req     = 1'b0;
    gif.rand_in = '0;

    // Reset for two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gap_top", int'(gif.gap_top), RST_ROW);
    chk("reset_valid", int'(gif.valid), 0);
    chk("reset_busy", int'(gif.busy), 0);
    reset = 1'b0;
    ready_at = cyc;

    // Minimum-latency requests
    issue(0, 1);
    issue(9, 1);
    drain();

    // Worst case with ignored extra reqs
    issue(1023, 1);
    spam(20);
    repeat (40) @(posedge clk);
    #1;
    spam(200);
    drain();

    // Abort by reset mid-reduction
    issue(37, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_gap_top", int'(gif.gap_top), RST_ROW);
    chk("abort_busy", int'(gif.busy), 0);
    chk("abort_valid", int'(gif.valid), 0);
    prev_m   = RST_ROW;
    ready_at = cyc;
    issue(37, 1);
    drain();

    // Random requests, back-to-back or with gaps, with ignored extras
    for (int i = 0; i < 500; i++) begin
      int r;
      case ($urandom_range(0, 9))
        0:       r = 1023;
        1:       r = $urandom_range(0, 9);
        default: r = $urandom_range(0, 1023);
      endcase
      issue(r, 1);
      if ($urandom_range(0, 2) == 0) spam($urandom_range(1, 120));
      if ($urandom_range(0, 1) == 0) begin
        int g;
        g = $urandom_range(0, 3);
        while (cyc < ready_at + g) begin
          @(posedge clk); #1;
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
